arbitro_terminais: RTL and testbench

//  Sequential arbiter sharing the two output terminals (LED matrix, LED bar) between the
//  two access stations HH0/HH1. Takes each station's authenticated request, its terminal

---
 rtl/arbitro_terminais_if.sv | 45 ++++
 rtl/arbitro_terminais.sv | 197 +++++++++++++++++++
 tb/tb_arbitro_terminais.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/arbitro_terminais_if.sv
// ---------------------------------------------------------------------------
// arbitro_terminais_if
//   Bundle of the station-side and terminal-side signals of the terminal
//   arbiter (arbitro_terminais). Clock and reset are not part of the bundle.
//
//   Station inputs  : REQ0/REQ1 (request), SEL0/SEL1 (0=matrix, 1=LEDs),
//                     CF0/CF1 (function code)
//   Arbiter outputs : GNT0/GNT1, FMATRIZ/FLEDS (decoder codes),
//                     MATRIZ_BUSY/LEDS_BUSY, MATRIZ_OWNER/LEDS_OWNER,
//                     CONFLICT_CNT
//
//   Modports: master = station/stimulus side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface arbitro_terminais_if #(
  parameter int CF_W  = 3,
  parameter int CNT_W = 8
);
  logic             REQ0;
  logic             REQ1;
  logic             SEL0;
  logic             SEL1;
  logic [CF_W-1:0]  CF0;
  logic [CF_W-1:0]  CF1;
  logic             GNT0;
  logic             GNT1;
  logic [CF_W-1:0]  FMATRIZ;
  logic [CF_W-1:0]  FLEDS;
  logic             MATRIZ_BUSY;
  logic             LEDS_BUSY;
  logic             MATRIZ_OWNER;
  logic             LEDS_OWNER;
  logic [CNT_W-1:0] CONFLICT_CNT;

  modport master (
    output REQ0, REQ1, SEL0, SEL1, CF0, CF1,
    input  GNT0, GNT1, FMATRIZ, FLEDS, MATRIZ_BUSY, LEDS_BUSY,
           MATRIZ_OWNER, LEDS_OWNER, CONFLICT_CNT
  );

  modport slave (
    input  REQ0, REQ1, SEL0, SEL1, CF0, CF1,
    output GNT0, GNT1, FMATRIZ, FLEDS, MATRIZ_BUSY, LEDS_BUSY,
           MATRIZ_OWNER, LEDS_OWNER, CONFLICT_CNT
  );
endinterface

// File: rtl/arbitro_terminais.sv
// ---------------------------------------------------------------------------
// arbitro_terminais
//   Shares the two output terminals (LED matrix = terminal 0, LED bar =
//   terminal 1) between access stations HH0/HH1. Each terminal has its own
//   IDLE/BUSY/SWITCH FSM with a round-robin pointer for simultaneous requests
//   and a hold counter that forces a handover after MAX_HOLD cycles when the
//   other station is waiting. The decoder codes FMATRIZ/FLEDS are registered.
//
//   Ports:
//     CLK  - clock, all state on rising edge
//     RST  - synchronous active-high reset
//     bus  - arbitro_terminais_if.slave: REQx/SELx/CFx in; GNTx, FMATRIZ,
//            FLEDS, *_BUSY, *_OWNER, CONFLICT_CNT out
//
//   Optional feature: define ARB_CONFLICT_CNT_EN to build the saturating
//   contention counter; otherwise CONFLICT_CNT is tied to 0.
// ---------------------------------------------------------------------------
module arbitro_terminais #(
  parameter int CF_W     = 3,
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic                CLK,
  input  logic                RST,
  arbitro_terminais_if.slave  bus
);

  localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_SWITCH = 2'd2
  } state_e;

  // Index 0 = matrix terminal, index 1 = LED terminal.
  state_e            state_q [2];
  state_e            state_d [2];
  logic              owner_q [2];
  logic              owner_d [2];
  logic              rr_q    [2];
  logic              rr_d    [2];
  logic [HOLD_W-1:0] hold_q  [2];
  logic [HOLD_W-1:0] hold_d  [2];
  logic [CF_W-1:0]   code_q  [2];
  logic [CF_W-1:0]   code_d  [2];
  logic              event_d [2];

  // want[t][u]: station u requests terminal t.
  logic [1:0]        want    [2];
  logic [CF_W-1:0]   cf_u    [2];

  function automatic logic [HOLD_W-1:0] hold_sat_inc(input logic [HOLD_W-1:0] h);
    return (h == HOLD_LAST) ? h : h + 1'b1;
  endfunction

  always_comb begin
    want[0] = {bus.REQ1 & ~bus.SEL1, bus.REQ0 & ~bus.SEL0};
    want[1] = {bus.REQ1 &  bus.SEL1, bus.REQ0 &  bus.SEL0};
    cf_u[0] = bus.CF0;
    cf_u[1] = bus.CF1;
  end

  // State register
  always_ff @(posedge CLK) begin
    for (int t = 0; t < 2; t++) begin
      if (RST) begin
        state_q[t] <= ST_IDLE;
        owner_q[t] <= 1'b0;
        rr_q[t]    <= 1'b0;
        hold_q[t]  <= '0;
        code_q[t]  <= '0;
      end else begin
        state_q[t] <= state_d[t];
        owner_q[t] <= owner_d[t];
        rr_q[t]    <= rr_d[t];
        hold_q[t]  <= hold_d[t];
        code_q[t]  <= code_d[t];
      end
    end
  end

  // Next-state logic
  always_comb begin
    for (int t = 0; t < 2; t++) begin
      state_d[t] = state_q[t];
      owner_d[t] = owner_q[t];
      rr_d[t]    = rr_q[t];
      hold_d[t]  = hold_q[t];
      event_d[t] = 1'b0;
      case (state_q[t])
        ST_IDLE: begin
          hold_d[t] = '0;
          if (&want[t]) begin
            // Simultaneous request: pointer decides, then favours the loser.
            state_d[t] = ST_BUSY;
            owner_d[t] = rr_q[t];
            rr_d[t]    = ~rr_q[t];
            event_d[t] = 1'b1;
          end else if (want[t][0]) begin
            state_d[t] = ST_BUSY;
            owner_d[t] = 1'b0;
          end else if (want[t][1]) begin
            state_d[t] = ST_BUSY;
            owner_d[t] = 1'b1;
          end
        end
        ST_BUSY: begin
          if (!want[t][owner_q[t]]) begin
            state_d[t] = want[t][~owner_q[t]] ? ST_SWITCH : ST_IDLE;
            hold_d[t]  = '0;
          end else if (want[t][~owner_q[t]] && (hold_q[t] == HOLD_LAST)) begin
            // Forced preemption: both stations want the terminal here.
            state_d[t] = ST_SWITCH;
            hold_d[t]  = '0;
            event_d[t] = 1'b1;
          end else begin
            hold_d[t]  = hold_sat_inc(hold_q[t]);
          end
        end
        ST_SWITCH: begin
          hold_d[t] = '0;
          if (want[t][~owner_q[t]]) begin
            state_d[t] = ST_BUSY;
            owner_d[t] = ~owner_q[t];
          end else if (want[t][owner_q[t]]) begin
            state_d[t] = ST_BUSY;
          end else begin
            state_d[t] = ST_IDLE;
          end
        end
        default: begin
          state_d[t] = ST_IDLE;
          hold_d[t]  = '0;
        end
      endcase
    end
  end

  // Output logic: the terminal code follows the owner's CF only while BUSY.
  always_comb begin
    for (int t = 0; t < 2; t++) begin
      code_d[t] = '0;
      if (state_d[t] == ST_BUSY) begin
        code_d[t] = cf_u[owner_d[t]];
      end
    end
  end

  logic busy_m;
  logic busy_l;

  assign busy_m           = (state_q[0] == ST_BUSY);
  assign busy_l           = (state_q[1] == ST_BUSY);
  assign bus.MATRIZ_BUSY  = busy_m;
  assign bus.LEDS_BUSY    = busy_l;
  assign bus.MATRIZ_OWNER = busy_m & owner_q[0];
  assign bus.LEDS_OWNER   = busy_l & owner_q[1];
  assign bus.FMATRIZ      = code_q[0];
  assign bus.FLEDS        = code_q[1];
  // BUSY is only entered or kept while the owner wants that terminal, so a
  // BUSY owner is by construction still targeting it.
  assign bus.GNT0         = (busy_m & ~owner_q[0]) | (busy_l & ~owner_q[1]);
  assign bus.GNT1         = (busy_m &  owner_q[0]) | (busy_l &  owner_q[1]);

`ifdef ARB_CONFLICT_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  function automatic logic [CNT_W-1:0] cnt_add_sat(input logic [CNT_W-1:0] a,
                                                   input logic [1:0]       inc);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W + 1)'(inc);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  always_comb begin
    cnt_d = cnt_add_sat(cnt_q, {1'b0, event_d[0]} + {1'b0, event_d[1]});
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.CONFLICT_CNT = cnt_q;
`else
  logic unused_event;
  assign unused_event     = event_d[0] ^ event_d[1];
  assign bus.CONFLICT_CNT = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_arbitro_terminais.sv
module tb_arbitro_terminais;
  localparam int CF_W     = 3;
  localparam int CNT_W    = 8;
  localparam int MAX_HOLD = 8;
`ifdef ARB_CONFLICT_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arbitro_terminais_if #(.CF_W(CF_W), .CNT_W(CNT_W)) bus ();

  arbitro_terminais #(.CF_W(CF_W), .MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       g0;
    logic       g1;
    logic [2:0] fm;
    logic [2:0] fl;
    logic       mb;
    logic       lb;
    logic       mo;
    logic       lo;
    logic [7:0] cnt;
  } out_t;

  typedef struct {
    string      name;
    logic       rst;
    logic       r0;
    logic       s0;
    logic [2:0] c0;
    logic       r1;
    logic       s1;
    logic [2:0] c1;
    out_t       exp;
  } vec_t;

  int    n_cmp = 0;
  int    n_bad = 0;
  out_t  exp_q [$];
  string name_q[$];
  vec_t  vecs  [$];

  function automatic vec_t mk(string n, logic rs,
                              logic r0, logic s0, logic [2:0] c0,
                              logic r1, logic s1, logic [2:0] c1,
                              logic g0, logic g1, logic [2:0] fm, logic [2:0] fl,
                              logic mb, logic lb, logic mo, logic lo, int cnt);
    vec_t v;
    v.name = n; v.rst = rs;
    v.r0 = r0; v.s0 = s0; v.c0 = c0;
    v.r1 = r1; v.s1 = s1; v.c1 = c1;
    v.exp = '{g0: g0, g1: g1, fm: fm, fl: fl, mb: mb, lb: lb, mo: mo, lo: lo,
              cnt: 8'(cnt)};
    return v;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic apply(input vec_t v);
    out_t  got;
    out_t  want;
    string nm;
    rst      = v.rst;
    bus.REQ0 = v.r0; bus.SEL0 = v.s0; bus.CF0 = v.c0;
    bus.REQ1 = v.r1; bus.SEL1 = v.s1; bus.CF1 = v.c1;
    want = v.exp;
    if (!CNT_ON) want.cnt = '0;
    exp_q.push_back(want);
    name_q.push_back(v.name);
    @(posedge clk);
    #1;
    got = '{g0: bus.GNT0, g1: bus.GNT1, fm: bus.FMATRIZ, fl: bus.FLEDS,
            mb: bus.MATRIZ_BUSY, lb: bus.LEDS_BUSY, mo: bus.MATRIZ_OWNER,
            lo: bus.LEDS_OWNER, cnt: bus.CONFLICT_CNT};
    want = exp_q.pop_front();
    nm   = name_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got gnt=%b%b fm=%b fl=%b busy=%b%b own=%b%b cnt=%0d, expected gnt=%b%b fm=%b fl=%b busy=%b%b own=%b%b cnt=%0d",
               nm, got.g0, got.g1, got.fm, got.fl, got.mb, got.lb, got.mo, got.lo, got.cnt,
               want.g0, want.g1, want.fm, want.fl, want.mb, want.lb, want.mo, want.lo, want.cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.REQ0 = 1'b0; bus.SEL0 = 1'b0; bus.CF0 = '0;
    bus.REQ1 = 1'b0; bus.SEL1 = 1'b0; bus.CF1 = '0;

    // Reset with random inputs, then idle.
    for (int i = 0; i < 2; i++)
      vecs.push_back(mk("rst_rand", 1, 1'($urandom), 1'($urandom), 3'($urandom),
                        1'($urandom), 1'($urandom), 3'($urandom),
                        0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0));
    for (int i = 0; i < 2; i++)
      vecs.push_back(mk("idle", 0, 0, 0, 3'b000, 0, 0, 3'b000,
                        0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0));
    // Single station on matrix.
    vecs.push_back(mk("t2_grant", 0, 1, 0, 3'b101, 0, 0, 3'b000,
                      1, 0, 3'b101, 3'b000, 1, 0, 0, 0, 0));
    vecs.push_back(mk("t2_hold",  0, 1, 0, 3'b101, 0, 0, 3'b000,
                      1, 0, 3'b101, 3'b000, 1, 0, 0, 0, 0));
    vecs.push_back(mk("t2_drop",  0, 0, 0, 3'b101, 0, 0, 3'b000,
                      0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0));
    // Both stations on different terminals, CF tracking.
    vecs.push_back(mk("t3_both",    0, 1, 0, 3'b010, 1, 1, 3'b110,
                      1, 1, 3'b010, 3'b110, 1, 1, 0, 1, 0));
    vecs.push_back(mk("t3_cftrack", 0, 1, 0, 3'b111, 1, 1, 3'b110,
                      1, 1, 3'b111, 3'b110, 1, 1, 0, 1, 0));
    vecs.push_back(mk("t3_drop",    0, 0, 0, 3'b111, 0, 1, 3'b110,
                      0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0));
    // Owner moves from matrix to LEDs.
    vecs.push_back(mk("sel_grant", 0, 1, 0, 3'b100, 0, 0, 3'b000,
                      1, 0, 3'b100, 3'b000, 1, 0, 0, 0, 0));
    vecs.push_back(mk("sel_move",  0, 1, 1, 3'b100, 0, 0, 3'b000,
                      1, 0, 3'b000, 3'b100, 0, 1, 0, 0, 0));
    vecs.push_back(mk("sel_drop",  0, 0, 1, 3'b100, 0, 0, 3'b000,
                      0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0));

    foreach (vecs[i]) apply(vecs[i]);

    // Contention on LEDs: MAX_HOLD cycles for station 0, blank, then station 1.
    apply(mk("t4_rst", 1, 0, 0, 3'b000, 0, 0, 3'b000,
             0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0));
    for (int i = 0; i < MAX_HOLD; i++)
      apply(mk("t4_own0", 0, 1, 1, 3'b011, 1, 1, 3'b100,
               1, 0, 3'b000, 3'b011, 0, 1, 0, 0, 1));
    apply(mk("t4_blank", 0, 1, 1, 3'b011, 1, 1, 3'b100,
             0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 2));
    for (int i = 0; i < 2; i++)
      apply(mk("t4_own1", 0, 1, 1, 3'b011, 1, 1, 3'b100,
               0, 1, 3'b000, 3'b100, 0, 1, 0, 1, 2));
    apply(mk("t4_drop", 0, 0, 1, 3'b011, 0, 1, 3'b100,
             0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 2));

    // Release with no contender, then re-request.
    apply(mk("t5_grant", 0, 0, 0, 3'b000, 1, 1, 3'b001,
             0, 1, 3'b000, 3'b001, 0, 1, 0, 1, 2));
    apply(mk("t5_drop",  0, 0, 0, 3'b000, 0, 1, 3'b001,
             0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 2));
    apply(mk("t5_regnt", 0, 0, 0, 3'b000, 1, 1, 3'b001,
             0, 1, 3'b000, 3'b001, 0, 1, 0, 1, 2));

    // Reset while station 1 owns LEDs, then matrix contention and handover on drop.
    apply(mk("t6_rst",     1, 0, 0, 3'b000, 1, 1, 3'b001,
             0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0));
    apply(mk("t6_contend", 0, 1, 0, 3'b110, 1, 0, 3'b011,
             1, 0, 3'b110, 3'b000, 1, 0, 0, 0, 1));
    apply(mk("t6_switch",  0, 0, 0, 3'b110, 1, 0, 3'b011,
             0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 1));
    apply(mk("t6_own1",    0, 0, 0, 3'b110, 1, 0, 3'b011,
             0, 1, 3'b011, 3'b000, 1, 0, 1, 0, 1));
    apply(mk("t6_drop",    0, 0, 0, 3'b110, 0, 0, 3'b011,
             0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
